// File: rtl/hex_display_driver.sv
// Converts an unsigned value to DIGITS active-low 7-segment codes, in hex or
// in decimal via a serial double-dabble, with optional leading-zero blanking.
module hex_display_driver #(
  parameter int WIDTH    = 64,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  dec_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_shift;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_bcd_ovf;
  logic                r_dec;
  logic                r_done;
  logic                r_ovf;
  logic [7*DIGITS-1:0] r_seg;

  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W-1:0]    w_hex_digits;
  logic                w_hex_ovf;
  logic [BCD_W-1:0]    w_digits;
  logic                w_ovf;
  logic [DIGITS-1:0]   w_nz;
  logic [7*DIGITS-1:0] w_seg;

  function automatic logic [6:0] f_enc(input logic [3:0] d);
    f_enc = 7'h7F;
    case (d)
      4'h0: f_enc = 7'h40;
      4'h1: f_enc = 7'h79;
      4'h2: f_enc = 7'h24;
      4'h3: f_enc = 7'h30;
      4'h4: f_enc = 7'h19;
      4'h5: f_enc = 7'h12;
      4'h6: f_enc = 7'h02;
      4'h7: f_enc = 7'h78;
      4'h8: f_enc = 7'h00;
      4'h9: f_enc = 7'h10;
      4'hA: f_enc = 7'h08;
      4'hB: f_enc = 7'h03;
      4'hC: f_enc = 7'h46;
      4'hD: f_enc = 7'h21;
      4'hE: f_enc = 7'h06;
      4'hF: f_enc = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (load) w_state_next = dec_mode ? S_CONVERT : S_UPDATE;
      S_CONVERT: if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = S_UPDATE;
      S_UPDATE:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Add-3 correction on every BCD digit before the next shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                    r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
    end

    if (WIDTH > BCD_W) begin : g_hex_wide
      assign w_hex_digits = r_shift[BCD_W-1:0];
      assign w_hex_ovf    = |r_shift[WIDTH-1:BCD_W];
    end else if (WIDTH == BCD_W) begin : g_hex_exact
      assign w_hex_digits = r_shift;
      assign w_hex_ovf    = 1'b0;
    end else begin : g_hex_narrow
      assign w_hex_digits = {{(BCD_W - WIDTH){1'b0}}, r_shift};
      assign w_hex_ovf    = 1'b0;
    end
  endgenerate

  assign w_digits = r_dec ? r_bcd     : w_hex_digits;
  assign w_ovf    = r_dec ? r_bcd_ovf : w_hex_ovf;

  // w_nz[i]: some digit at position i or higher is nonzero.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign w_nz[gi] = |w_digits[BCD_W-1:4*gi];
      if (gi == 0 || BLANK_LZ == 0) begin : g_plain
        assign w_seg[7*gi +: 7] = w_ovf ? 7'h3F : f_enc(w_digits[4*gi +: 4]);
      end else begin : g_blank
        assign w_seg[7*gi +: 7] = w_ovf ? 7'h3F :
                                  (!w_nz[gi] ? 7'h7F : f_enc(w_digits[4*gi +: 4]));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_bcd_ovf <= 1'b0;
      r_dec     <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_seg     <= {DIGITS{7'h7F}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (load) begin
          r_shift   <= value;
          r_dec     <= dec_mode;
          r_bcd     <= '0;
          r_cnt     <= '0;
          r_bcd_ovf <= 1'b0;
        end
        S_CONVERT: begin
          r_bcd     <= {w_bcd_adj[BCD_W-2:0], r_shift[WIDTH-1]};
          r_shift   <= r_shift << 1;
          r_bcd_ovf <= r_bcd_ovf | w_bcd_adj[BCD_W-1];
          r_cnt     <= r_cnt + 1'b1;
        end
        S_UPDATE: begin
          r_seg  <= w_seg;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign overflow = r_ovf;
  assign seg      = r_seg;

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: arithmetic display model checked every cycle,
// plus directed transactions with hand-computed segment patterns.
module tb_hex_display_driver;
  localparam int W = 64;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [63:0] value = '0;
  logic        dec_mode = 1'b0;
  logic        busy, done, overflow;
  logic [27:0] seg;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  hex_display_driver #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dec_mode(dec_mode),
    .busy(busy), .done(done), .overflow(overflow), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[d];
  endfunction

  // Returns {overflow, seg} for a value as the display should show it.
  function automatic logic [28:0] model_disp(input logic [63:0] v, input logic dec);
    logic [27:0]     s;
    logic            ov;
    int              dig [4];
    int              msd;
    longint unsigned rem;
    rem = v;
    msd = 0;
    if (dec) begin
      ov = (v >= 64'd10000);
      for (int i = 0; i < 4; i++) begin
        dig[i] = int'(rem % 10);
        rem    = rem / 10;
      end
    end else begin
      ov = (v[63:16] != 48'd0);
      for (int i = 0; i < 4; i++) dig[i] = int'((v >> (4 * i)) & 64'hF);
    end
    for (int i = 0; i < 4; i++) if (dig[i] != 0) msd = i;
    for (int i = 0; i < 4; i++)
      s[7*i +: 7] = ov ? 7'h3F : ((i > msd) ? 7'h7F : enc(dig[i]));
    return {ov, s};
  endfunction

  // Timing model: a request finishes a fixed number of edges after acceptance.
  logic [27:0] m_seg = {4{7'h7F}};
  logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [28:0] m_pend = '0;
  int          m_rem = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_ovf  <= 1'b0;
      m_seg  <= {4{7'h7F}};
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_seg  <= m_pend[27:0];
          m_ovf  <= m_pend[28];
        end
      end else if (load) begin
        m_pend <= model_disp(value, dec_mode);
        m_rem  <= dec_mode ? W + 1 : 1;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, m_busy});
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_ovf",  {31'd0, overflow}, {31'd0, m_ovf});
      check("model_seg",  {4'd0, seg}, {4'd0, m_seg});
    end
  end

  task automatic run_txn(input logic [63:0] v, input logic dec, input logic [27:0] exp_seg,
                         input logic exp_ovf, input int exp_lat);
    int n;
    @(posedge clk); #1;
    load = 1'b1; value = v; dec_mode = dec;
    @(posedge clk); #1;
    load = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check("latency", n, exp_lat);
    check("seg", {4'd0, seg}, {4'd0, exp_seg});
    check("ovf", {31'd0, overflow}, {31'd0, exp_ovf});
    $display("txn value=%h dec=%0d seg=%h ovf=%0d latency=%0d", v, dec, seg, overflow, n);
  endtask

  initial begin
    int dones;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_seg",  {4'd0, seg}, {4'd0, {4{7'h7F}}});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, overflow}, 32'd0);
    $display("txn reset idle seg=%h", seg);

    run_txn(64'd9999,  1'b1, {7'h10, 7'h10, 7'h10, 7'h10}, 1'b0, 65);
    run_txn(64'd10000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 65);
    run_txn(64'd5,     1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0, 65);
    run_txn(64'd0,     1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 65);
    run_txn(64'd1234,  1'b1, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0, 65);
    run_txn('1,        1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 65);
    run_txn(64'hBEEF,  1'b0, {7'h03, 7'h06, 7'h06, 7'h0E}, 1'b0, 1);
    run_txn(64'h10000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 1);
    run_txn(64'h0A05,  1'b0, {7'h7F, 7'h08, 7'h40, 7'h12}, 1'b0, 1);
    run_txn(64'h0,     1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 1);

    // Load pulsed mid-conversion must be dropped.
    @(posedge clk); #1;
    load = 1'b1; value = 64'd42; dec_mode = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    dones = 0;
    for (int c = 1; c <= 90; c++) begin
      if (c == 10) begin load = 1'b1; value = 64'd7777; end
      if (c == 11) load = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("ignored_load_dones", dones, 1);
    check("ignored_load_seg", {4'd0, seg}, {4'd0, {7'h7F, 7'h7F, 7'h19, 7'h24}});
    $display("txn ignored-load dones=%0d seg=%h", dones, seg);

    // Reset mid-conversion aborts the request.
    @(posedge clk); #1;
    load = 1'b1; value = 64'd1234; dec_mode = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_seg",  {4'd0, seg}, {4'd0, {4{7'h7F}}});
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst = 1'b1;
    load = 1'b1; value = 64'h3; dec_mode = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_seg", {4'd0, seg}, {4'd0, {7'h7F, 7'h7F, 7'h7F, 7'h30}});
    repeat (80) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_dones", dones, 0);
    $display("txn abort stray_dones=%0d seg=%h", dones, seg);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
